// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller for the E stage.
// Owns HI/LO, sequences multi-cycle mult/multu/div/divu with a busy counter,
// serves mthi/mtlo/mfhi/mflo and raises the D-stage stall request.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  op,
    input  logic        start,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic               latch_s;
    logic               done_s;
    logic               busy_r;
    logic [31:0]        op_a_r;
    logic [31:0]        op_b_r;
    logic               sgn_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic [31:0]        hi_nx_s;
    logic [31:0]        lo_nx_s;
    logic [63:0]        mul_s;
    logic [63:0]        div_s;
    logic               stall_s;
    logic [31:0]        rd_data_s;
    logic               is_muldiv_s;

    // 32x32 multiply; operands are sign- or zero-extended to 64 bits so the
    // low 64 bits of the product are correct for both signed and unsigned.
    function automatic logic [63:0] mul_res(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ax * bx;
    endfunction

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. Returns {remainder, quotient}.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] div_res(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        sgn);
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] q;
        logic [31:0] r;
        logic        neg_q;
        logic        neg_r;
        neg_r = sgn & a[31];
        neg_q = sgn & (a[31] ^ b[31]);
        a_mag = neg_r ? (32'd0 - a) : a;
        b_mag = (sgn & b[31]) ? (32'd0 - b) : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = a_mag;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        q = neg_q ? (32'd0 - q_mag) : q_mag;
        r = neg_r ? (32'd0 - r_mag) : r_mag;
        return {r, q};
    endfunction

    // State, counter and busy flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

    // Next-state and counter logic; ops arriving while busy are ignored
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        latch_s    = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && ((op == OP_MULT) || (op == OP_MULTU))) begin
                    state_nx_s = ST_MUL;
                    cnt_nx_s   = CNT_W'(MULT_CYCLES);
                    latch_s    = 1'b1;
                end else if (start && ((op == OP_DIV) || (op == OP_DIVU))) begin
                    state_nx_s = ST_DIV;
                    cnt_nx_s   = CNT_W'(DIV_CYCLES);
                    latch_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_nx_s = cnt_r - CNT_W'(1);
                if (cnt_r <= CNT_W'(1)) begin
                    // guard against a zero count so the FSM can never wedge
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_IDLE;
                    done_s     = 1'b1;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output and HI/LO update logic
    always_comb begin
        hi_nx_s     = hi_r;
        lo_nx_s     = lo_r;
        mul_s       = mul_res(op_a_r, op_b_r, sgn_r);
        div_s       = div_res(op_a_r, op_b_r, sgn_r);
        is_muldiv_s = (op == OP_MULT) || (op == OP_MULTU) ||
                      (op == OP_DIV)  || (op == OP_DIVU);
        stall_s     = d_is_md & (busy_r | (start & is_muldiv_s));
        case (op)
            OP_MFHI: rd_data_s = hi_r;
            OP_MFLO: rd_data_s = lo_r;
            default: rd_data_s = 32'd0;
        endcase
        case (state_r)
            ST_IDLE: begin
                if (start && (op == OP_MTHI)) begin
                    hi_nx_s = rs_val;
                end else if (start && (op == OP_MTLO)) begin
                    lo_nx_s = rs_val;
                end else begin
                    hi_nx_s = hi_r;
                    lo_nx_s = lo_r;
                end
            end
            ST_MUL: begin
                if (done_s) begin
                    hi_nx_s = mul_s[63:32];
                    lo_nx_s = mul_s[31:0];
                end else begin
                    hi_nx_s = hi_r;
                    lo_nx_s = lo_r;
                end
            end
            ST_DIV: begin
                // a zero divisor burns the full latency but leaves HI/LO alone
                if (done_s && (op_b_r != 32'd0)) begin
                    hi_nx_s = div_s[63:32];
                    lo_nx_s = div_s[31:0];
                end else begin
                    hi_nx_s = hi_r;
                    lo_nx_s = lo_r;
                end
            end
            default: begin
                hi_nx_s = hi_r;
                lo_nx_s = lo_r;
            end
        endcase
    end

    // Operand capture at start and HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a_r <= 32'd0;
            op_b_r <= 32'd0;
            sgn_r  <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else begin
            if (latch_s) begin
                op_a_r <= rs_val;
                op_b_r <= rt_val;
                sgn_r  <= (op == OP_MULT) || (op == OP_DIV);
            end
            hi_r <= hi_nx_s;
            lo_r <= lo_nx_s;
        end
    end

    assign busy    = busy_r;
    assign hi      = hi_r;
    assign lo      = lo_r;
    assign stall   = stall_s;
    assign rd_data = rd_data_s;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: each mult/div pushes its expected HI/LO and
// busy length; a monitor pops and compares when busy falls.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  op;
    logic        start;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (op),
        .start   (start),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int cyc);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.cycles = cyc;
        sb_q.push_back(e);
    endtask

    // Drives one op for one cycle starting at posedge+1; returns at posedge+1.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        start = 1'b1;
        rs_val = a;
        rt_val = b;
        d_is_md = 1'b1;
        #1;
        check32("stall_start", {31'd0, stall}, {31'd0, (o >= 4'd1) && (o <= 4'd4)});
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 4'd0;
        d_is_md = 1'b0;
        rs_val = 32'hDEAD_BEEF;
        rt_val = 32'h0BAD_F00D;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy still %b after 40 cycles, required 0", busy);
    endtask

    // Monitor: measures busy length and checks HI/LO on the first idle cycle
    initial begin
        exp_t e;
        logic busy_prev;
        int   busy_cnt;
        busy_prev = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy_prev = 1'b0;
                busy_cnt = 0;
            end else begin
                if (busy) begin
                    busy_cnt++;
                end else if (busy_prev) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: busy fell with hi=%h lo=%h, no result expected", hi, lo);
                    end else begin
                        e = sb_q.pop_front();
                        check32("res_hi", hi, e.hi);
                        check32("res_lo", lo, e.lo);
                        check32("busy_len", 32'(busy_cnt), 32'(e.cycles));
                    end
                    busy_cnt = 0;
                end
                busy_prev = busy;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        op = 4'd0;
        start = 1'b0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        d_is_md = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_stall", {31'd0, stall}, 32'd0);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        check32("rst_rd", rd_data, 32'd0);
        @(posedge clk);
        #1;

        // mult -3 * 7, plus an ignored mult while busy
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        issue(4'd1, 32'hFFFF_FFFD, 32'd7);
        d_is_md = 1'b1;
        start = 1'b1;
        op = 4'd1;
        rs_val = 32'd2;
        rt_val = 32'd2;
        #1;
        check32("stall_busy", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 4'd7;
        rs_val = 32'h5555_5555;
        d_is_md = 1'b0;
        #1;
        check32("stall_busy_nomd", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 4'd0;
        wait_idle();
        check32("mthi_ignored_hi", hi, 32'hFFFF_FFFF);

        // divu 100 / 7
        push_exp(32'd2, 32'd14, 10);
        issue(4'd4, 32'd100, 32'd7);
        wait_idle();

        // div -7 / 2
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();

        // div overflow case
        push_exp(32'd0, 32'h8000_0000, 10);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // mthi then mfhi/mflo
        issue(4'd7, 32'h0000_1234, 32'd0);
        op = 4'd5;
        start = 1'b1;
        #1;
        check32("mfhi", rd_data, 32'h0000_1234);
        op = 4'd6;
        #1;
        check32("mflo", rd_data, 32'h8000_0000);
        op = 4'd0;
        start = 1'b0;
        #1;
        check32("rd_none", rd_data, 32'd0);
        @(posedge clk);
        #1;

        // divide by zero keeps prior HI/LO
        issue(4'd7, 32'h0000_0011, 32'd0);
        issue(4'd8, 32'h0000_0022, 32'd0);
        check32("mthi_hi", hi, 32'h0000_0011);
        check32("mtlo_lo", lo, 32'h0000_0022);
        push_exp(32'h0000_0011, 32'h0000_0022, 10);
        issue(4'd4, 32'd1234, 32'd0);
        wait_idle();

        // back-to-back multu on the first idle cycle
        push_exp(32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        @(posedge clk);
        #1;

        // reset in cycle 3 of a div discards it
        issue(4'd3, 32'd50, 32'd5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        d_is_md = 1'b1;
        #1;
        check32("stall_pre_rst", {31'd0, stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        check32("midrst_busy", {31'd0, busy}, 32'd0);
        check32("midrst_stall", {31'd0, stall}, 32'd0);
        check32("midrst_hi", hi, 32'd0);
        check32("midrst_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        d_is_md = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check32("post_rst_hi", hi, 32'd0);
        check32("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide controller for the E stage of the pipelined MIPS core.
- Owns the HI/LO registers and sequences multi-cycle mult/multu/div/divu operations with a busy counter.
- Serves mthi/mtlo/mfhi/mflo.
- Generates the stall request that the hazard unit uses to freeze D when an MDU instruction would collide with an operation still in progress.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles of mult/multu (legal range ≥1).
- DIV_CYCLES, 10, busy duration in cycles of div/divu (legal range ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op  input  4  E-stage MDU opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none.
- start  input  1  E-stage instruction valid this cycle; op is acted on only when start=1.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- d_is_md  input  1  D-stage instruction is any MDU op (1–8).
- busy  output  1  a mult/div is in progress.
- stall  output  1  request to freeze D and insert a bubble into E.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- rd_data  output  32  mfhi/mflo result: hi when op=5, lo when op=6, else 0. Combinational from the registered HI/LO.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, stall=0, rd_data=0.
  - Reset mid-operation discards the pending result immediately.
- States:
  - IDLE: accepts ops.
  - MUL, DIV: counting.
- IDLE transitions, on a rising edge with start=1:
  - op 1/2: latch operands, load counter=MULT_CYCLES, go to MUL.
  - op 3/4: latch operands, load counter=DIV_CYCLES, go to DIV.
  - op 7: hi<=rs_val. No busy.
  - op 8: lo<=rs_val. No busy.
  - op 5/6/none: no state change.
- MUL/DIV:
  - Counter decrements each edge.
  - On the edge where counter goes 1→0, HI/LO take the result and the state returns to IDLE.
  - busy=1 for exactly N cycles following the start edge.
  - New HI/LO become visible in the first cycle with busy=0.
- start with any op while busy=1: ignored, no state change (the pipeline guarantees this never occurs through stall).
- Arithmetic, operands latched at start so later operand changes have no effect:
  - mult: signed 32×32→64; HI=upper, LO=lower.
  - multu: unsigned 32×32→64; HI=upper, LO=lower.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): runs the full DIV_CYCLES with busy, then HI and LO retain their prior values.
- stall = d_is_md & (busy | (start & op∈{1,2,3,4})).
  - Combinational.
  - Non-MDU instructions in D never stall on this unit.
- rd_data reflects HI/LO as of the current cycle.
  - An mthi/mtlo in the previous cycle is visible.
  - A same-cycle mthi/mtlo is not visible.
- Back-to-back: a new mult/div may start on the first cycle with busy=0.

Test Plan:
- mult, rs=0xFFFFFFFD (−3), rt=7 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; stall=1 during busy whenever d_is_md=1.
- divu, rs=100, rt=7 -> busy for 10 cycles; then LO=14, HI=2.
- div, rs=0xFFFFFFF9 (−7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- div by 0 with prior HI=0x11, LO=0x22 -> busy 10 cycles; HI/LO unchanged.
- mthi 0x1234, then mflo/mfhi -> rd_data=0x1234 for op=5 the next cycle; start with mult while busy ignored (HI/LO reflect only the first op).
- start=1 with op=1 and d_is_md=1 in the same cycle -> stall=1 that cycle; assert reset_n=0 at cycle 3 of a div -> busy=0, HI=LO=0 immediately.
